ring_osc_freq_counter: RTL and testbench
========================================

# ring_osc_freq_counter

Parametrised successor to the two-ring analog oscillator top. It owns `NUM_RINGS` oscillator enables and measures the frequency of one selected ring in the `clk` domain. Each ring output is synchronised into `clk`, and its rising edges are counted over a programmable gate window. The result is latched with done/overflow status, in one-shot or continuous mode. It sits between the ring/driver analog macros and the digital pins.

## Interface
- `NUM_RINGS`, 4, number of ring oscillator channels (2..16).
- `SEL_W`, 2, select width; must satisfy 2^SEL_W ≥ NUM_RINGS.
- `GATE_W`, 16, width of the gate-length input.
- `COUNT_W`, 24, result counter width.
- `SETTLE_CYCLES`, 8, cycles between ring enable and gate open; must be ≥ 4.

- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `ena`  in  1  design enable; when 0, `start` is ignored (an in-flight measurement completes).
- `ring_in`  in  NUM_RINGS  asynchronous ring outputs, pre-divided so that frequency < f_clk/4.
- `ring_en`  out  NUM_RINGS  one-hot oscillator enable; all zeros when idle.
- `sel`  in  SEL_W  ring select, sampled on accepted start.
- `gate_cycles`  in  GATE_W  gate length G in clk cycles, sampled on accepted start; 0 is treated as 1.
- `continuous`  in  1  1 = auto-restart after DONE; sampled each DONE cycle.
- `start`  in  1  level; accepted only in IDLE with `ena`=1.
- `busy`  out  1  high in SETTLE and MEASURE.
- `done`  out  1  one-cycle pulse in the DONE state.
- `count`  out  COUNT_W  last measured edge count; holds until the next DONE.
- `overflow`  out  1  last measurement saturated; updates with `count`.
- `sel_err`  out  1  last accepted `sel` ≥ NUM_RINGS; updates on accept.

## Operation
- **Synchroniser.** Each `ring_in` bit has a 2-flop synchroniser. The selected synced bit feeds a third flop. edge = s2 & ~s3. The mux is placed before the third flop, and the mux select uses the latched selection.
- **FSM states:** IDLE → SETTLE → MEASURE → DONE → (IDLE | SETTLE).
- **IDLE:** `ring_en`=0 and `busy`=0. Accepted start does the following:
  - latch `sel` and G = max(`gate_cycles`, 1);
  - clear the edge accumulator;
  - set `sel_err`;
  - go to SETTLE.
- **SETTLE:** `ring_en`[sel_latched]=1 (all zeros if `sel_err`). Lasts exactly `SETTLE_CYCLES` cycles and flushes stale synchroniser history. Edges are not counted.
- **MEASURE:** lasts exactly G cycles, timed by a down-counter loaded with G. The accumulator increments on each edge. It saturates at 2^COUNT_W−1, and any edge arriving while saturated sets an internal overflow flag.
- **DONE (1 cycle):**
  - `count` ← accumulator, `overflow` ← flag, `done`=1;
  - `ring_en` stays asserted;
  - if `continuous`=1, go to SETTLE, reusing the latched sel/G and clearing the accumulator/flag;
  - otherwise go to IDLE.
- **Start handling:** `start` during SETTLE, MEASURE or DONE is ignored. `sel`/`gate_cycles` changes mid-measurement have no effect.
- **sel_err:** the measurement still runs full length and reports `count`=0 and `overflow`=0.
- **Continuous mode exit:** deasserting `continuous` ends the loop at the next DONE. There is no abort other than reset.
- **Reset (any state, including mid-measurement):** IDLE; `ring_en`, `busy`, `done`, `count`, `overflow`, `sel_err`, accumulator, gate counter and all synchroniser flops are set to 0.

## Timing
- `start` is accepted at edge T, then:
  - `busy`=1 from T+1;
  - MEASURE occupies cycles T+1+SETTLE_CYCLES .. T+SETTLE_CYCLES+G;
  - `done`=1 and the new `count` is visible in cycle T+1+SETTLE_CYCLES+G, where `busy`=0.
- In one-shot mode, IDLE follows DONE, so the earliest next accept is in cycle T+2+SETTLE_CYCLES+G.
- In continuous mode, `done` pulses every SETTLE_CYCLES+G+1 cycles.
- Edge-to-count latency through the synchroniser is 3 cycles. A ring edge is counted if its detect pulse falls inside a MEASURE cycle.
- For a periodic ring with period P cycles (P ≥ 4) where G is a multiple of P, the required count is exactly G/P. Otherwise it is floor(G/P) or ceil(G/P).

## Test plan
- **Basic measurement:** reset, then `sel`=2, G=1000, ring_in[2] period 10 cycles, pulse `start` → `ring_en`=4'b0100 during busy; `done` at T+1009 with SETTLE_CYCLES=8; `count`=100, `overflow`=0; `ring_en`=0 afterwards.
- **Saturation:** COUNT_W=8, ring period 4, G=2000 → `count`=255, `overflow`=1. Rerun with G=400 → `count`=100, `overflow`=0.
- **Start while busy:** re-pulse `start` with `sel`=1 at T+500 → ignored; exactly one `done`, result still from ring 2.
- **Continuous mode:** `continuous`=1, G=100, period 5 → `done` every 109 cycles with `count`=20 each time; clear `continuous` → exactly one further `done`, then IDLE.
- **Reset mid-measurement:** `rst_n`=0 for one cycle during MEASURE → next cycle all outputs 0, state IDLE. A fresh start measures correctly and the first count excludes pre-reset edges.
- **Edge cases:** `sel`=3 with NUM_RINGS=3 → `sel_err`=1, `ring_en`=0, `count`=0. Separately, G=0 → gate of 1 cycle; `done` at T+10.

Source files
------------

// File: rtl/ring_osc_freq_counter.sv
// Ring oscillator enable and frequency counter: synchronises the selected ring,
// counts its rising edges over a programmable gate window and latches the result.
module ring_osc_freq_counter #(
  parameter int unsigned NUM_RINGS     = 4,
  parameter int unsigned SEL_W         = 2,
  parameter int unsigned GATE_W        = 16,
  parameter int unsigned COUNT_W       = 24,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [NUM_RINGS-1:0] ring_in,
  output logic [NUM_RINGS-1:0] ring_en,
  input  logic [SEL_W-1:0]     sel,
  input  logic [GATE_W-1:0]    gate_cycles,
  input  logic                 continuous,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [COUNT_W-1:0]   count,
  output logic                 overflow,
  output logic                 sel_err
);

  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [COUNT_W-1:0] ACC_MAX = '1;

  logic [1:0]           state, state_d;
  logic [NUM_RINGS-1:0] sync1, sync2;
  logic                 sync3;
  logic                 sel_bit, edge_det;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 sel_err_d;
  logic [GATE_W-1:0]    gate_q, gate_d;
  logic [GATE_W-1:0]    gate_cnt, gate_cnt_d;
  logic [SETTLE_W-1:0]  settle_cnt, settle_cnt_d;
  logic [COUNT_W-1:0]   acc, acc_d;
  logic                 ovf_flag, ovf_flag_d;
  logic [NUM_RINGS-1:0] ring_en_d;
  logic                 busy_d, done_d, overflow_d;
  logic [COUNT_W-1:0]   count_d;

  // Mux on the latched select ahead of the third flop; invalid selects read as 0.
  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < int'(NUM_RINGS); i++) begin
      if (!sel_err && sel_q == SEL_W'(i)) sel_bit = sync2[i];
    end
  end

  assign edge_det = sel_bit & ~sync3;

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state;
    sel_d        = sel_q;
    sel_err_d    = sel_err;
    gate_d       = gate_q;
    gate_cnt_d   = gate_cnt;
    settle_cnt_d = settle_cnt;
    acc_d        = acc;
    ovf_flag_d   = ovf_flag;
    count_d      = count;
    overflow_d   = overflow;
    ring_en_d    = '0;
    busy_d       = 1'b0;
    done_d       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start && ena) begin
          sel_d        = sel;
          sel_err_d    = (32'(sel) >= NUM_RINGS);
          gate_d       = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
          acc_d        = '0;
          ovf_flag_d   = 1'b0;
          settle_cnt_d = SETTLE_W'(SETTLE_CYCLES - 1);
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == '0) begin
          gate_cnt_d = gate_q;
          state_d    = ST_MEASURE;
        end else begin
          settle_cnt_d = settle_cnt - SETTLE_W'(1);
        end
      end
      ST_MEASURE: begin
        if (edge_det && !sel_err) begin
          if (acc == ACC_MAX) ovf_flag_d = 1'b1;
          else                acc_d      = acc + COUNT_W'(1);
        end
        if (gate_cnt == GATE_W'(1)) state_d    = ST_DONE;
        else                        gate_cnt_d = gate_cnt - GATE_W'(1);
      end
      ST_DONE: begin
        if (continuous) begin
          acc_d        = '0;
          ovf_flag_d   = 1'b0;
          settle_cnt_d = SETTLE_W'(SETTLE_CYCLES - 1);
          state_d      = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Result is published as the machine enters DONE, so it is visible with the pulse.
    if (state_d == ST_DONE) begin
      count_d    = acc_d;
      overflow_d = ovf_flag_d;
      done_d     = 1'b1;
    end
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_MEASURE);
    for (int i = 0; i < int'(NUM_RINGS); i++) begin
      ring_en_d[i] = (state_d != ST_IDLE) && !sel_err_d && (sel_d == SEL_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sync1      <= '0;
      sync2      <= '0;
      sync3      <= 1'b0;
      sel_q      <= '0;
      sel_err    <= 1'b0;
      gate_q     <= '0;
      gate_cnt   <= '0;
      settle_cnt <= '0;
      acc        <= '0;
      ovf_flag   <= 1'b0;
      count      <= '0;
      overflow   <= 1'b0;
      ring_en    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      sync1      <= ring_in;
      sync2      <= sync1;
      sync3      <= sel_bit;
      sel_q      <= sel_d;
      sel_err    <= sel_err_d;
      gate_q     <= gate_d;
      gate_cnt   <= gate_cnt_d;
      settle_cnt <= settle_cnt_d;
      acc        <= acc_d;
      ovf_flag   <= ovf_flag_d;
      count      <= count_d;
      overflow   <= overflow_d;
      ring_en    <= ring_en_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_ring_osc_freq_counter.sv
// Self-checking bench for ring_osc_freq_counter: table vectors, hand-written
// corner sequences and randomized measurements against an arithmetic model.
module tb_ring_osc_freq_counter;

  localparam int unsigned NUM_RINGS     = 3;
  localparam int unsigned SEL_W         = 2;
  localparam int unsigned GATE_W        = 16;
  localparam int unsigned COUNT_W       = 8;
  localparam int unsigned SETTLE_CYCLES = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 ena;
  logic [NUM_RINGS-1:0] ring_in;
  logic [NUM_RINGS-1:0] ring_en;
  logic [SEL_W-1:0]     sel;
  logic [GATE_W-1:0]    gate_cycles;
  logic                 continuous;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [COUNT_W-1:0]   count;
  logic                 overflow;
  logic                 sel_err;

  int n_checks = 0;
  int n_pass   = 0;
  int period [NUM_RINGS];
  int ph     [NUM_RINGS];

  ring_osc_freq_counter #(
    .NUM_RINGS(NUM_RINGS), .SEL_W(SEL_W), .GATE_W(GATE_W),
    .COUNT_W(COUNT_W), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ring_in(ring_in), .ring_en(ring_en),
    .sel(sel), .gate_cycles(gate_cycles), .continuous(continuous), .start(start),
    .busy(busy), .done(done), .count(count), .overflow(overflow), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  // Free-running square waves; period < 2 holds the ring low.
  always @(negedge clk) begin
    for (int i = 0; i < int'(NUM_RINGS); i++) begin
      if (period[i] < 2) begin
        ph[i]      = 0;
        ring_in[i] = 1'b0;
      end else begin
        ph[i]      = (ph[i] >= period[i] - 1) ? 0 : ph[i] + 1;
        ring_in[i] = (ph[i] < period[i] / 2);
      end
    end
  end

  typedef struct {
    int sel;
    int per;
    int gate;
    int exp_count;
    int exp_ovf;
    int exp_err;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input longint got, input longint lo, input longint hi);
    n_checks++;
    if (got >= lo && got <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < limit);
  endtask

  // One-shot measurement; poke > 0 re-pulses start with sel=1 that many cycles after accept.
  task automatic measure(input int s, input int p, input int g, input int lo, input int hi,
                         input int exp_ovf, input int exp_err, input int poke);
    int geff, lat, extra, exp_en;
    int unsigned held;
    geff   = (g == 0) ? 1 : g;
    exp_en = exp_err ? 0 : (1 << s);
    if (s < int'(NUM_RINGS)) period[s] = p;
    repeat (30) @(negedge clk);
    sel = SEL_W'(s); gate_cycles = GATE_W'(g); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", busy, 1, 1);
    check("ring_en_busy", ring_en, exp_en, exp_en);
    check("sel_err", sel_err, exp_err, exp_err);
    lat = 0;
    while (!done && lat < geff + int'(SETTLE_CYCLES) + 50) begin
      @(posedge clk); #1;
      lat++;
      if (poke > 0 && lat == poke)     begin start = 1'b1; sel = SEL_W'(1); end
      if (poke > 0 && lat == poke + 3) start = 1'b0;
    end
    check("done_latency", lat, geff + int'(SETTLE_CYCLES), geff + int'(SETTLE_CYCLES));
    check("busy_in_done", busy, 0, 0);
    check("ring_en_in_done", ring_en, exp_en, exp_en);
    check("count", count, lo, hi);
    check("overflow", overflow, exp_ovf, exp_ovf);
    held  = count;
    extra = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("extra_done", extra, 0, 0);
    check("idle_busy", busy, 0, 0);
    check("idle_ring_en", ring_en, 0, 0);
    check("count_holds", count, held, held);
  endtask

  initial begin
    int lat, extra, s, p, g, lo, hi, err;

    vecs[0] = '{sel: 2, per: 10, gate: 1000, exp_count: 100, exp_ovf: 0, exp_err: 0};
    vecs[1] = '{sel: 0, per: 4,  gate: 2000, exp_count: 255, exp_ovf: 1, exp_err: 0};
    vecs[2] = '{sel: 0, per: 4,  gate: 400,  exp_count: 100, exp_ovf: 0, exp_err: 0};
    vecs[3] = '{sel: 1, per: 6,  gate: 60,   exp_count: 10,  exp_ovf: 0, exp_err: 0};
    vecs[4] = '{sel: 3, per: 5,  gate: 50,   exp_count: 0,   exp_ovf: 0, exp_err: 1};

    for (int i = 0; i < int'(NUM_RINGS); i++) begin
      period[i] = 0;
      ph[i]     = 0;
    end
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; continuous = 1'b0;
    sel = '0; gate_cycles = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ring_en", ring_en, 0, 0);
    check("rst_busy", busy, 0, 0);
    check("rst_done", done, 0, 0);
    check("rst_count", count, 0, 0);
    check("rst_overflow", overflow, 0, 0);
    check("rst_sel_err", sel_err, 0, 0);
    @(negedge clk) rst_n = 1'b1;

    // Start is ignored while ena is low.
    ena = 1'b0; start = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("ena_low_busy", busy, 0, 0);
    start = 1'b0; ena = 1'b1;

    for (int i = 0; i < 5; i++) begin
      measure(vecs[i].sel, vecs[i].per, vecs[i].gate, vecs[i].exp_count, vecs[i].exp_count,
              vecs[i].exp_ovf, vecs[i].exp_err, -1);
    end

    // Start while busy: ring 1 runs at a different rate, result must come from ring 2.
    period[1] = 7;
    measure(2, 10, 1000, 100, 100, 0, 0, 500);

    // Zero gate behaves as a single-cycle gate.
    measure(0, 8, 0, 0, 1, 0, 0, -1);

    // Continuous mode.
    period[0] = 5;
    repeat (30) @(negedge clk);
    sel = SEL_W'(0); gate_cycles = GATE_W'(100); continuous = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(300, lat);
    check("cont_first_latency", lat, 108, 108);
    check("cont_count", count, 20, 20);
    for (int k = 0; k < 2; k++) begin
      wait_done(300, lat);
      check("cont_period", lat, 109, 109);
      check("cont_count", count, 20, 20);
    end
    @(posedge clk); #1;
    continuous = 1'b0;
    wait_done(300, lat);
    check("cont_last_period", lat, 108, 108);
    check("cont_last_count", count, 20, 20);
    extra = 0;
    repeat (150) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("cont_no_more_done", extra, 0, 0);
    check("cont_idle_busy", busy, 0, 0);
    check("cont_idle_ring_en", ring_en, 0, 0);

    // Reset in the middle of a measurement.
    period[1] = 10;
    repeat (30) @(negedge clk);
    sel = SEL_W'(1); gate_cycles = GATE_W'(500); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (300) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_ring_en", ring_en, 0, 0);
    check("midrst_busy", busy, 0, 0);
    check("midrst_done", done, 0, 0);
    check("midrst_count", count, 0, 0);
    check("midrst_overflow", overflow, 0, 0);
    check("midrst_sel_err", sel_err, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_stays_idle", busy, 0, 0);
    measure(1, 10, 200, 20, 20, 0, 0, -1);

    // Randomized measurements against floor/ceil of G/P.
    for (int it = 0; it < 12; it++) begin
      s   = int'($urandom_range(0, 3));
      p   = int'($urandom_range(4, 12));
      g   = int'($urandom_range(1, 300));
      err = (s >= int'(NUM_RINGS)) ? 1 : 0;
      lo  = err ? 0 : g / p;
      hi  = err ? 0 : ((g % p == 0) ? g / p : g / p + 1);
      measure(s, p, g, lo, hi, 0, err, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
